// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and count-width helper for the synchronous FIFO
package fifo_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/fifo_sync_param_if.sv
// fifo_sync_param_if: FIFO handshake/status bus
// master drives w_en/in_data/r_en; slave (the FIFO) drives out_data, rd_valid,
// full/empty/almost_full/almost_empty, count, overflow/underflow.
interface fifo_sync_param_if
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int CW = cnt_width(DEPTH);
  logic             w_en;
  logic [WIDTH-1:0] in_data;
  logic             r_en;
  logic [WIDTH-1:0] out_data;
  logic             rd_valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;
  modport master (
    output w_en, in_data, r_en,
    input  out_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input  w_en, in_data, r_en,
    output out_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: WIDTH x DEPTH storage, one write port, one registered read port
// clk, rst_n (clears read register only), we/waddr/wdata, re/raddr, rdata.
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk)
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: synchronous FIFO with registered count and status flags
// clk, rst_n (sync, active-low), bus (fifo_sync_param_if.slave).
// Define FIFO_SYNC_PARAM_ERR_EN to enable sticky overflow/underflow flags.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input logic              clk,
  input logic              rst_n,
  fifo_sync_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  logic [AW-1:0]    wptr, rptr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rdata;
  logic             wr, rd, rd_valid, full_i, empty_i;
  assign full_i  = cnt == CW'(DEPTH);
  assign empty_i = cnt == '0;
  // a concurrent read frees a slot at full; reading an empty FIFO never falls through
  assign wr = rst_n && bus.w_en && (!full_i || bus.r_en);
  assign rd = rst_n && bus.r_en && !empty_i;
  always_ff @(posedge clk)
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      rd_valid <= 1'b0;
    end else begin
      wptr     <= wptr + AW'(wr);
      rptr     <= rptr + AW'(rd);
      cnt      <= cnt + CW'(wr) - CW'(rd);
      rd_valid <= rd;
    end
  fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (wr),
    .waddr(wptr),
    .wdata(bus.in_data),
    .re   (rd),
    .raddr(rptr),
    .rdata(rdata)
  );
  assign bus.out_data     = rdata;
  assign bus.rd_valid     = rd_valid;
  assign bus.count        = cnt;
  assign bus.full         = full_i;
  assign bus.empty        = empty_i;
  assign bus.almost_full  = cnt >= CW'(AF_LEVEL);
  assign bus.almost_empty = cnt <= CW'(AE_LEVEL);
`ifdef FIFO_SYNC_PARAM_ERR_EN
  logic ovf, udf;
  always_ff @(posedge clk)
    if (!rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= ovf | (bus.w_en & full_i & ~bus.r_en);
      udf <= udf | (bus.r_en & empty_i);
    end
  assign bus.overflow  = ovf;
  assign bus.underflow = udf;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif
endmodule
